// File: rtl/dtcm_ctrl_pkg.sv
// dtcm_ctrl_pkg: shared encodings for the data-TCM access controller.
//   DATA_SIZE   : default byte-address width
//   SIZE_B/H/W  : access size encoding used by st_size and ld_size (2'b11 acts as word)
//   state_t     : write-sequencer states, also exported on dbg_state
//   size_len    : number of bytes moved for a given size code
package dtcm_ctrl_pkg;

    localparam int DATA_SIZE = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CORE_WR = 2'd1,
        ST_LDR_WR  = 2'd2
    } state_t;

    // The illegal code 2'b11 falls into the default arm and moves a full word.
    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dtcm_ctrl_ld_fmt.sv
// dtcm_ld_fmt: combinational load formatter.
//   rdata       in  32  little-endian word read from the TCM at the load address
//   size        in  2   SIZE_B / SIZE_H / SIZE_W (2'b11 treated as word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  formatted load result
module dtcm_ld_fmt
    import dtcm_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    always_comb begin
        data = rdata;
        case (size)
            SIZE_B:  data = {{24{~is_unsigned & rdata[7]}},  rdata[7:0]};
            SIZE_H:  data = {{16{~is_unsigned & rdata[15]}}, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: data-TCM access controller.
// Serialises core stores (1/2/4 bytes) and loader byte writes onto the TCM's
// single byte write port, arbitrates round-robin between the two writers,
// stalls core loads while a write sequence is in flight, and formats load data.
//   clk, rst_n                      clock, asynchronous active-low reset
//   st_valid/st_ready/st_size/st_addr/st_data      core store request
//   ldr_valid/ldr_ready/ldr_addr/ldr_byte          loader byte write request
//   ld_valid/ld_addr/ld_size/ld_unsigned           core load
//   ld_data, ld_stall               formatted load result, load hold request
//   busy                            write sequence in flight
//   mem_wen/mem_waddr/mem_wdata     TCM byte write port
//   mem_raddr/mem_rdata             TCM 32-bit read port (mem_raddr = ld_addr)
//   dbg_state                       current sequencer state
//
// Handshake: a request transfers on a cycle where valid && ready are both high
// at the rising edge. ready never depends on the same requester's valid, the
// requester holds valid and its payload stable until the transfer, and ready
// is forced low while rst_n is low.
module dtcm_ctrl
    import dtcm_ctrl_pkg::*;
#(
    parameter int ADDR_W = DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_size,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic              ldr_valid,
    output logic              ldr_ready,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_byte,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    output logic [31:0]       ld_data,
    output logic              ld_stall,
    output logic              busy,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output state_t            dbg_state
);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [31:0]       data;
    logic [2:0]        len;
    logic [1:0]        cnt;
    logic              pref;

    logic [2:0] len_m1;
    logic       last_byte;
    logic       slot;
    logic       st_grant;
    logic       ldr_grant;

    // len is 1/2/4, so len-1 fits in cnt's two bits (0/1/3).
    assign len_m1    = len - 3'd1;
    assign last_byte = (cnt == len_m1[1:0]);

    // A new writer may be accepted when idle, on the final byte of a core
    // store (giving gap-free back-to-back sequences), or during a loader write.
    assign slot = (state == ST_IDLE) || (state == ST_LDR_WR) ||
                  ((state == ST_CORE_WR) && last_byte);

    assign st_ready  = rst_n && slot && (!ldr_valid || !pref);
    assign ldr_ready = rst_n && slot && (!st_valid  ||  pref);
    assign st_grant  = st_valid  && st_ready;
    assign ldr_grant = ldr_valid && ldr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            base  <= '0;
            data  <= '0;
            len   <= 3'd1;
            cnt   <= 2'd0;
            pref  <= 1'b0;
        end else if (slot) begin
            cnt <= 2'd0;
            if (st_grant) begin
                state <= ST_CORE_WR;
                base  <= st_addr;
                data  <= st_data;
                len   <= size_len(st_size);
                pref  <= 1'b1;
            end else if (ldr_grant) begin
                // A loader write reuses the core datapath as a 1-byte sequence.
                state <= ST_LDR_WR;
                base  <= ldr_addr;
                data  <= {24'd0, ldr_byte};
                len   <= 3'd1;
                pref  <= 1'b0;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            cnt <= cnt + 2'd1;
        end
    end

    // Write port derives straight from registered state so an asynchronous
    // reset drops mem_wen without waiting for a clock.
    assign mem_wen   = (state != ST_IDLE);
    assign busy      = mem_wen;
    assign mem_waddr = base + ADDR_W'(cnt);
    assign mem_wdata = data[8*cnt +: 8];
    assign dbg_state = state;

    assign mem_raddr = ld_addr;
    assign ld_stall  = ld_valid && busy;

    dtcm_ld_fmt u_ld_fmt (
        .rdata       (mem_rdata),
        .size        (ld_size),
        .is_unsigned (ld_unsigned),
        .data        (ld_data)
    );

endmodule

// File: tb/tb_dtcm_ctrl.sv
// tb_dtcm_ctrl: self-checking bench for dtcm_ctrl. The bench plays the TCM
// (256-byte array indexed by the low address byte) and keeps a transaction
// level model: bytes still to write, round-robin preference and an expected
// byte-write queue.
module tb_dtcm_ctrl;
    import dtcm_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic clr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        st_valid, st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr, st_data;
    logic        ldr_valid, ldr_ready;
    logic [31:0] ldr_addr;
    logic [7:0]  ldr_byte;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [31:0] ld_data;
    logic        ld_stall, busy, mem_wen;
    logic [31:0] mem_waddr, mem_raddr, mem_rdata;
    logic [7:0]  mem_wdata;
    state_t      dbg_state;

    dtcm_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data),
        .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_addr(ldr_addr), .ldr_byte(ldr_byte),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .ld_data(ld_data), .ld_stall(ld_stall), .busy(busy),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- TCM model ----------------
    logic [7:0] tcm [256];
    logic [7:0] ra0, ra1, ra2, ra3;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) tcm[i] <= 8'h00;
        end else if (mem_wen) begin
            tcm[mem_waddr[7:0]] <= mem_wdata;
        end
    end

    assign ra0 = mem_raddr[7:0];
    assign ra1 = mem_raddr[7:0] + 8'd1;
    assign ra2 = mem_raddr[7:0] + 8'd2;
    assign ra3 = mem_raddr[7:0] + 8'd3;
    assign mem_rdata = {tcm[ra3], tcm[ra2], tcm[ra1], tcm[ra0]};

    // ---------------- request queues / scoreboard ----------------
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] size; } st_req_t;
    typedef struct { logic [31:0] addr; logic [7:0] b; } ldr_req_t;
    typedef struct { logic [31:0] addr; logic [1:0] size; logic uns; logic [31:0] exp; } ld_vec_t;

    st_req_t     st_q[$];
    ldr_req_t    ldr_q[$];
    logic [39:0] exp_q[$];     // {addr, byte} in write order
    int          rem;          // write cycles left, counting the current one
    logic        mpref;        // 0: core preferred, 1: loader preferred
    int          errors, checks;

    int          wen_log[$];
    int          grant_log[$];  // 1 = core, 2 = loader
    logic [31:0] waddr_log[$];
    logic [31:0] ovl_waddr_q[$];
    logic [31:0] last_ld_data;
    logic        last_stall, last_st_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        return {tcm[i + 8'd3], tcm[i + 8'd2], tcm[i + 8'd1], tcm[i]};
    endfunction

    // Load formatting from first principles: keep the low n bytes, then
    // fill the upper bits with copies of the top kept bit when signed.
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] sz, input logic uns);
        int          n;
        logic [31:0] mask, v;
        n = size_bytes(sz);
        if (n == 4) return w;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = w & mask;
        if (!uns && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic reset_model();
        rem = 0;
        mpref = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle();
        logic        exp_sr, exp_lr, sg, lg;
        logic [39:0] e;
        st_req_t     s;
        ldr_req_t    l;
        int          n;
        st_valid = (st_q.size() > 0);
        if (st_valid) begin
            st_addr = st_q[0].addr; st_data = st_q[0].data; st_size = st_q[0].size;
        end
        ldr_valid = (ldr_q.size() > 0);
        if (ldr_valid) begin
            ldr_addr = ldr_q[0].addr; ldr_byte = ldr_q[0].b;
        end
        @(negedge clk);
        exp_sr = rst_n && (rem <= 1) && (!ldr_valid || !mpref);
        exp_lr = rst_n && (rem <= 1) && (!st_valid || mpref);
        chk("st_ready", {31'd0, st_ready}, {31'd0, exp_sr});
        chk("ldr_ready", {31'd0, ldr_ready}, {31'd0, exp_lr});
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, rem > 0});
        chk("busy", {31'd0, busy}, {31'd0, rem > 0});
        chk("ld_stall", {31'd0, ld_stall}, {31'd0, ld_valid && rem > 0});
        chk("mem_raddr", mem_raddr, ld_addr);
        if (ld_valid && rem == 0)
            chk("ld_data", ld_data, fmt(ref_word(ld_addr), ld_size, ld_unsigned));
        if (mem_wen) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_waddr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("mem_waddr", mem_waddr, e[39:8]);
                chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
            waddr_log.push_back(mem_waddr);
        end
        wen_log.push_back(int'(mem_wen));
        if (st_valid && st_ready) begin
            grant_log.push_back(1);
            if (mem_wen) ovl_waddr_q.push_back(mem_waddr);
        end
        if (ldr_valid && ldr_ready) grant_log.push_back(2);
        last_ld_data  = ld_data;
        last_stall    = ld_stall;
        last_st_ready = st_ready;
        // model advance across the coming edge
        sg = st_valid && exp_sr;
        lg = ldr_valid && exp_lr;
        if (!rst_n) begin
            reset_model();
        end else if (sg) begin
            s = st_q.pop_front();
            n = size_bytes(s.size);
            for (int i = 0; i < n; i++) exp_q.push_back({s.addr + 32'(i), s.data[8*i +: 8]});
            rem = n;
            mpref = 1'b1;
        end else if (lg) begin
            l = ldr_q.pop_front();
            exp_q.push_back({l.addr, l.b});
            rem = 1;
            mpref = 1'b0;
        end else if (rem > 0) begin
            rem--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (st_q.size() == 0 && ldr_q.size() == 0 && rem == 0) break;
            cycle();
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_logs();
        wen_log.delete(); grant_log.delete(); waddr_log.delete(); ovl_waddr_q.delete();
    endtask

    // Checks that mem_wen was high for exactly n cycles with no gap.
    task automatic check_wen_run(input string name, input int n);
        int first, last, ones;
        first = -1; last = -1; ones = 0;
        foreach (wen_log[i]) if (wen_log[i] != 0) begin
            if (first < 0) first = i;
            last = i;
            ones++;
        end
        chk({name, "_count"}, 32'(ones), 32'(n));
        chk({name, "_nogap"}, 32'(last - first + 1), 32'(n));
    endtask

    // ---------------- test ----------------
    ld_vec_t vecs[12];
    int      exp_grants[6];

    initial begin
        vecs[0]  = '{32'h10, 2'b10, 1'b0, 32'hA1B2C3D4};
        vecs[1]  = '{32'h10, 2'b01, 1'b0, 32'hFFFFC3D4};
        vecs[2]  = '{32'h10, 2'b01, 1'b1, 32'h0000C3D4};
        vecs[3]  = '{32'h10, 2'b00, 1'b0, 32'hFFFFFFD4};
        vecs[4]  = '{32'h10, 2'b00, 1'b1, 32'h000000D4};
        vecs[5]  = '{32'h12, 2'b01, 1'b0, 32'hFFFFA1B2};
        vecs[6]  = '{32'h11, 2'b10, 1'b0, 32'h00A1B2C3};
        vecs[7]  = '{32'h10, 2'b11, 1'b0, 32'hA1B2C3D4};
        vecs[8]  = '{32'h3F, 2'b01, 1'b0, 32'hFFFF8000};
        vecs[9]  = '{32'h20, 2'b01, 1'b1, 32'h0000BEEF};
        vecs[10] = '{32'h20, 2'b01, 1'b0, 32'hFFFFBEEF};
        vecs[11] = '{32'h30, 2'b00, 1'b0, 32'h0000007F};
        exp_grants = '{1, 2, 1, 2, 1, 2};

        errors = 0; checks = 0;
        rst_n = 1'b0; clr = 1'b1;
        st_valid = 1'b1; st_size = 2'b00; st_addr = '0; st_data = '0;
        ldr_valid = 1'b1; ldr_addr = '0; ldr_byte = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_size = 2'b00; ld_unsigned = 1'b0;
        reset_model();

        // reset state: both writers requesting, nothing may be granted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
        chk("rst_ldr_ready", {31'd0, ldr_ready}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        @(posedge clk); #1;
        st_valid = 1'b0; ldr_valid = 1'b0; clr = 1'b0; rst_n = 1'b1;

        // word store then lw
        clear_logs();
        st_q.push_back('{32'h10, 32'hA1B2C3D4, 2'b10});
        drain(10);
        check_wen_run("sw_wen", 4);
        ld_valid = 1'b1; ld_addr = 32'h10; ld_size = 2'b10; ld_unsigned = 1'b0;
        cycle();
        chk("lw_0x10", last_ld_data, 32'hA1B2C3D4);
        ld_valid = 1'b0;

        // back-to-back sh then sb
        clear_logs();
        st_q.push_back('{32'h20, 32'h0000BEEF, 2'b01});
        st_q.push_back('{32'h30, 32'h0000007F, 2'b00});
        drain(10);
        check_wen_run("b2b_wen", 3);
        chk("b2b_overlap_n", 32'(ovl_waddr_q.size()), 32'd1);
        chk("b2b_overlap_addr", (ovl_waddr_q.size() > 0) ? ovl_waddr_q[0] : 32'hDEADBEEF, 32'h21);

        // contention held from reset
        rst_n = 1'b0;
        reset_model();
        st_q.push_back('{32'h60, 32'h00000011, 2'b00});
        st_q.push_back('{32'h62, 32'h00002233, 2'b01});
        st_q.push_back('{32'h65, 32'h00000044, 2'b00});
        ldr_q.push_back('{32'h70, 8'hAA});
        ldr_q.push_back('{32'h71, 8'hBB});
        ldr_q.push_back('{32'h72, 8'hCC});
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
        drain(30);
        chk("arb_grants_n", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("arb_grant_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'd0, 32'(exp_grants[i]));
        check_wen_run("arb_wen", 7);

        // load stall and sign
        st_q.push_back('{32'h40, 32'h00000080, 2'b00});
        cycle();
        ld_valid = 1'b1; ld_addr = 32'h40; ld_size = 2'b00; ld_unsigned = 1'b0;
        cycle();
        chk("lb_stall_on", {31'd0, last_stall}, 32'd1);
        cycle();
        chk("lb_stall_off", {31'd0, last_stall}, 32'd0);
        chk("lb_signed", last_ld_data, 32'hFFFFFF80);
        ld_unsigned = 1'b1;
        cycle();
        chk("lbu", last_ld_data, 32'h00000080);

        // table-driven load formatting
        foreach (vecs[i]) begin
            ld_valid = 1'b1; ld_addr = vecs[i].addr; ld_size = vecs[i].size; ld_unsigned = vecs[i].uns;
            cycle();
            chk("ld_table", last_ld_data, vecs[i].exp);
        end
        ld_valid = 1'b0;

        // reset in the middle of a word store
        st_q.push_back('{32'h50, 32'h11223344, 2'b10});
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("midrst_wen_async", {31'd0, mem_wen}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_st_ready", {31'd0, st_ready}, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("midrst_ready_after", {31'd0, last_st_ready}, 32'd1);
        chk("midrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("midrst_b0", {24'd0, tcm[8'h50]}, 32'h44);
        chk("midrst_b1", {24'd0, tcm[8'h51]}, 32'h33);
        chk("midrst_b2", {24'd0, tcm[8'h52]}, 32'h00);
        chk("midrst_b3", {24'd0, tcm[8'h53]}, 32'h00);

        // address wrap
        clear_logs();
        st_q.push_back('{32'hFFFFFFFE, 32'h01020304, 2'b10});
        drain(10);
        chk("wrap_n", 32'(waddr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("wrap_addr", (i < waddr_log.size()) ? waddr_log[i] : 32'hDEADBEEF, 32'hFFFFFFFE + 32'(i));

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (st_q.size() == 0 && $urandom_range(0, 2) == 0)
                st_q.push_back('{$urandom, $urandom, 2'($urandom_range(0, 3))});
            if (ldr_q.size() == 0 && $urandom_range(0, 2) == 0)
                ldr_q.push_back('{$urandom, 8'($urandom_range(0, 255))});
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr = $urandom;
            ld_size = 2'($urandom_range(0, 3));
            ld_unsigned = 1'($urandom_range(0, 1));
            cycle();
        end
        ld_valid = 1'b0;
        drain(40);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
